// File: rtl/nes_pad_receiver.sv
// Serial game-pad receiver for NES (8-bit) and SNES (16-bit) controllers.
// One poll per start pulse: latch strobe, then BUTTONS low/high serial clock phases, sampling
// every pad's data line at the end of each low phase. The result is presented as registered
// button state plus one-cycle newly-pressed flags qualified by valid.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-high reset
//   start     poll request pulse (ignored while a poll is in flight)
//   nes_data  one active-low serial data line per pad
//   nes_latch latch strobe shared by all pads (registered)
//   nes_clk   serial clock shared by all pads (registered)
//   buttons   current state, 1 = pressed, pad p bit i at [p*BUTTONS+i]
//   pressed   newly-pressed flags, non-zero only while valid is high
//   valid     one-cycle pulse when buttons/pressed update
//   busy      high from start acceptance until valid
module nes_pad_receiver #(
  parameter int unsigned NUM_PADS    = 1,
  parameter int unsigned BUTTONS     = 8,
  parameter int unsigned HALF_PERIOD = 150
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_PADS-1:0]           nes_data,
  output logic                          nes_latch,
  output logic                          nes_clk,
  output logic [NUM_PADS*BUTTONS-1:0]   buttons,
  output logic [NUM_PADS*BUTTONS-1:0]   pressed,
  output logic                          valid,
  output logic                          busy
);

  localparam int unsigned Width  = NUM_PADS * BUTTONS;
  // The phase counter also times the latch, which spans two half periods.
  localparam int unsigned PhaseW = $clog2(2 * HALF_PERIOD);
  localparam int unsigned CntW   = (BUTTONS > 1) ? $clog2(BUTTONS) : 1;

  localparam logic [PhaseW-1:0] LatchLast = PhaseW'(2 * HALF_PERIOD - 1);
  localparam logic [PhaseW-1:0] HalfLast  = PhaseW'(HALF_PERIOD - 1);
  localparam logic [CntW-1:0]   BitLast   = CntW'(BUTTONS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLatch,
    StLow,
    StHigh,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [PhaseW-1:0]   phase_q, phase_d;
  logic [CntW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [Width-1:0]    shift_q, shift_d;
  logic                latch_q, latch_d;
  logic                sclk_q, sclk_d;
  logic [Width-1:0]    buttons_q, buttons_d;
  logic [Width-1:0]    pressed_q, pressed_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    latch_d   = latch_q;
    sclk_d    = sclk_q;
    buttons_d = buttons_q;
    pressed_d = '0;
    valid_d   = 1'b0;
    busy_d    = busy_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StLatch;
          phase_d   = '0;
          bit_cnt_d = '0;
          latch_d   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      StLatch: begin
        if (phase_q == LatchLast) begin
          state_d = StLow;
          phase_d = '0;
          latch_d = 1'b0;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StLow: begin
        if (phase_q == HalfLast) begin
          phase_d = '0;
          // All pads sampled on the same edge into the current bit slot.
          for (int p = 0; p < NUM_PADS; p++) begin
            for (int i = 0; i < BUTTONS; i++) begin
              if (bit_cnt_q == CntW'(i)) begin
                shift_d[p*BUTTONS+i] = nes_data[p];
              end
            end
          end
          if (bit_cnt_q == BitLast) begin
            state_d = StDone;
          end else begin
            state_d = StHigh;
            sclk_d  = 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StHigh: begin
        if (phase_q == HalfLast) begin
          state_d   = StLow;
          phase_d   = '0;
          sclk_d    = 1'b0;
          bit_cnt_d = bit_cnt_q + 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      StDone: begin
        // Data lines are active-low; an unplugged pad floats high and reads as released.
        buttons_d = ~shift_q;
        pressed_d = ~shift_q & ~buttons_q;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      latch_q   <= 1'b0;
      sclk_q    <= 1'b0;
      buttons_q <= '0;
      pressed_q <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      latch_q   <= latch_d;
      sclk_q    <= sclk_d;
      buttons_q <= buttons_d;
      pressed_q <= pressed_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
    end
  end

  assign nes_latch = latch_q;
  assign nes_clk   = sclk_q;
  assign buttons   = buttons_q;
  assign pressed   = pressed_q;
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: doc/nes_pad_receiver.md
Name: nes_pad_receiver

Overview:
- Parametrised serial game-pad receiver that replaces the stubbed NES_Latch/NES_Clk wiring in the top level.
- Generates the shared latch and clock strobes and shifts in one data line per pad (NES 8-bit or SNES 16-bit frames).
- Presents registered button states plus single-cycle newly-pressed flags to the input controller.
- Polling is triggered once per frame by frame_end.

Parameters:
- NUM_PADS, 1, number of pads sharing latch/clock; legal range 1..4.
- BUTTONS, 8, bits per frame; 8 = NES, 16 = SNES; legal range 1..16.
- HALF_PERIOD, 150, system cycles per half serial-clock period (≈6 µs at 25.175 MHz); must be ≥1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  poll request pulse, normally frame_end.
- nes_data  in  NUM_PADS  serial data, one bit per pad, active-low (0 = pressed).
- nes_latch  out  1  latch strobe to all pads.
- nes_clk  out  1  serial clock to all pads.
- buttons  out  NUM_PADS*BUTTONS  current state, 1 = pressed; pad p bit i at [p*BUTTONS+i]; NES order A,B,Select,Start,Up,Down,Left,Right.
- pressed  out  NUM_PADS*BUTTONS  rising-edge flags, valid only while valid=1.
- valid  out  1  one-cycle pulse: buttons/pressed updated.
- busy  out  1  high from start acceptance until valid.

Behaviour:
- Clocking and reset:
  - Single clock, asynchronous active-high reset.
  - Reset forces FSM=IDLE and all outputs to 0, including nes_latch, nes_clk, buttons, pressed, valid and busy.
  - Reset mid-transfer aborts immediately; the partial shift register is discarded and does not reach buttons.
- Timing: phase counter counts 0..HALF_PERIOD-1; bit counter counts 0..BUTTONS-1.
- FSM:
  - IDLE: nes_latch=0, nes_clk=0, busy=0. start=1 → LATCH; counters cleared; busy=1 from the next cycle.
  - LATCH: nes_latch=1 for 2*HALF_PERIOD cycles → LOW.
  - LOW: nes_clk=0 for HALF_PERIOD cycles. On the last cycle, sample nes_data for every pad into shift bit[bit_cnt]. Then:
    - if bit_cnt==BUTTONS-1 → DONE;
    - otherwise → HIGH.
  - HIGH: nes_clk=1 for HALF_PERIOD cycles; bit_cnt+1 → LOW.
  - DONE, one cycle:
    - buttons ← ~shift;
    - pressed ← ~shift & ~buttons_old;
    - valid=1, busy=0 → IDLE.
- Outputs:
  - nes_latch and nes_clk are registered outputs (glitch-free).
  - BUTTONS-1 clock pulses are issued per frame.
- Latency: valid asserts (2*BUTTONS+1)*HALF_PERIOD+1 cycles after the edge sampling start. For B=8, H=4: 69 cycles.
- start handling:
  - start while busy is ignored; no queuing and no restart.
  - start coincident with DONE is also ignored.
- pressed is 0 whenever valid=0.
- buttons holds its value between frames.
- Open or unplugged pad: data pulled high reads as all released (0), never pressed.
- Pads are sampled on the same cycle; no per-pad skew.
- HALF_PERIOD=1 boundary: LATCH lasts 2 cycles and each LOW/HIGH phase lasts 1 cycle.

Test Plan:
- Reset during HIGH phase (NUM_PADS=1, B=8, H=4) → nes_clk and nes_latch go 0 asynchronously; buttons=0; busy=0; next start produces a normal 69-cycle frame.
- Single NES pad, data serialises A..Right = 0,1,1,1,0,1,1,1 (active-low) → valid at cycle 69 with buttons=8'b0001_0001 and pressed=8'b0001_0001. Check waveform: latch high 8 cycles, 7 clock pulses each 4 high / 4 low.
- Repeat the same frame → buttons unchanged, pressed=0. Next frame releases A and presses Right → buttons=8'b1001_0000, pressed=8'b1000_0000.
- NUM_PADS=2, pad0 data held 1, pad1 data held 0 → buttons=16'hFF00, pressed=16'hFF00 on the first frame.
- start re-pulsed at cycles 10 and 40 during a transfer → single valid at cycle 69, no extra latch pulse. start at cycle 70 begins a new frame.
- BUTTONS=16, H=1 (SNES) → latch 2 cycles, 15 clock pulses, valid at cycle 34; bit 15 sampled correctly.
